// File: rtl/stereolbm_run_ctrl.sv
// Per-frame run controller for the stereolbm_axis_cambm HLS core.
// Launches one ap_start per camera frame, tracks ap_ready/ap_done, and
// recovers the core from deadlock (persistent dl_block) or a hang (watchdog)
// by pulsing core_rst, waiting for idle, and reporting an error code.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for frame_start with enable high
// START   | ap_start asserted, waiting for ap_ready
// RUN     | core accepted the frame, waiting for ap_done
// RECOVER | core_rst asserted for RST_CYCLES cycles
// DRAIN   | reset released, waiting for ap_idle
module stereolbm_run_ctrl #(
  parameter int                WDOG_W     = 24,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 24'd2000000,
  parameter int                PERSIST    = 16,
  parameter int                RST_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_start,
  output logic        ap_start,
  input  logic        ap_ready,
  input  logic        ap_done,
  input  logic        ap_idle,
  input  logic        dl_block,
  output logic        core_rst,
  output logic        busy,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [15:0] frames_done,
  output logic [15:0] frames_dropped,
  output logic [7:0]  recover_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    RUN     = 3'd2,
    RECOVER = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam int PW = $clog2(PERSIST + 1);
  // The timer is a down-counter: loading LIMIT-1 and expiring at zero gives
  // the same timeout as counting up from zero to LIMIT-1.
  localparam logic [WDOG_W-1:0] WDOG_LOAD    = WDOG_LIMIT - 1'b1;
  localparam logic [WDOG_W-1:0] RST_LOAD     = WDOG_W'(RST_CYCLES - 1);
  localparam logic [PW-1:0]     PERSIST_LAST = PW'(PERSIST - 1);

  state_t            state;
  logic [WDOG_W-1:0] tmr;
  logic [PW-1:0]     persist;
  logic              in_run;
  logic              dl_hit;
  logic              tmr_tc;
  logic              launch;

  // Decode conditions shared by the state transitions.
  always_comb begin
    in_run = (state == START) || (state == RUN);
    dl_hit = in_run && dl_block && (persist == PERSIST_LAST);
    tmr_tc = (tmr == '0);
    launch = (state == IDLE) && enable && frame_start;
  end

  // Single-process FSM with registered outputs, counters and timers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      tmr            <= '0;
      persist        <= '0;
      ap_start       <= 1'b0;
      core_rst       <= 1'b0;
      busy           <= 1'b0;
      err_valid      <= 1'b0;
      err_code       <= 2'd0;
      frames_done    <= '0;
      frames_dropped <= '0;
      recover_cnt    <= '0;
    end else begin
      err_valid <= 1'b0;
      if (!tmr_tc) tmr <= tmr - 1'b1;
      persist <= (in_run && dl_block) ? persist + 1'b1 : '0;
      if (frame_start && !launch && (frames_dropped != '1))
        frames_dropped <= frames_dropped + 16'd1;

      case (state)
        IDLE: begin
          if (launch) begin
            state    <= START;
            ap_start <= 1'b1;
            busy     <= 1'b1;
            tmr      <= WDOG_LOAD;
            persist  <= '0;
          end
        end
        START, RUN: begin
          if ((state == START) ? (ap_ready && ap_done) : ap_done) begin
            // Completion outranks any error detected in the same cycle.
            state    <= IDLE;
            ap_start <= 1'b0;
            busy     <= 1'b0;
            persist  <= '0;
            if (frames_done != '1) frames_done <= frames_done + 16'd1;
          end else if (dl_hit || tmr_tc) begin
            state     <= RECOVER;
            ap_start  <= 1'b0;
            core_rst  <= 1'b1;
            err_valid <= 1'b1;
            err_code  <= dl_hit ? 2'd1 : 2'd2;
            tmr       <= RST_LOAD;
            persist   <= '0;
            if (recover_cnt != '1) recover_cnt <= recover_cnt + 8'd1;
          end else if (state == START && ap_ready) begin
            state    <= RUN;
            ap_start <= 1'b0;
            tmr      <= WDOG_LOAD;
          end
        end
        RECOVER: begin
          if (tmr_tc) begin
            state    <= DRAIN;
            core_rst <= 1'b0;
            tmr      <= WDOG_LOAD;
          end
        end
        DRAIN: begin
          if (ap_idle) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tmr_tc) begin
            state     <= RECOVER;
            core_rst  <= 1'b1;
            err_valid <= 1'b1;
            err_code  <= 2'd3;
            tmr       <= RST_LOAD;
            if (recover_cnt != '1) recover_cnt <= recover_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          ap_start <= 1'b0;
          core_rst <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/stereolbm_run_ctrl.md
Name: stereolbm_run_ctrl

Overview:
- Per-frame run controller for the stereolbm_axis_cambm HLS core.
- Issues ap_start once per camera frame and tracks the ap_ready/ap_done handshake.
- Watches the core's deadlock-monitor `block` output and a watchdog counter. On deadlock or hang it pulses a core reset, waits for idle, reports the error, and resumes.
- Sits between the camera frame-sync logic and the accelerator's ap_ctrl port.

Parameters:
- WDOG_W, 24, width of the watchdog counter.
- WDOG_LIMIT, 24'd2000000, watchdog timeout in cycles (START/RUN/DRAIN).
- PERSIST, 16, consecutive cycles dl_block must be high to declare deadlock (≥1).
- RST_CYCLES, 8, length of the core_rst pulse in cycles (≥1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  allow new frame launches.
- frame_start  in  1  one-cycle pulse at camera start of frame.
- ap_start  out  1  to core.
- ap_ready  in  1  from core.
- ap_done  in  1  from core.
- ap_idle  in  1  from core.
- dl_block  in  1  deadlock-monitor block output.
- core_rst  out  1  active-high reset to the core.
- busy  out  1  high in every state except IDLE.
- err_valid  out  1  one-cycle pulse on entry to RECOVER.
- err_code  out  2  1=deadlock, 2=watchdog in START/RUN, 3=watchdog in DRAIN; holds its last value.
- frames_done  out  16  completed frames, saturating.
- frames_dropped  out  16  frame_start pulses not launched, saturating.
- recover_cnt  out  8  recoveries performed, saturating.

Behaviour:
- Reset is asynchronous, active-high. All outputs 0, FSM=IDLE, all counters 0.
- States: IDLE, START, RUN, RECOVER, DRAIN.
- Outputs are registered. ap_start=1 exactly while in START; core_rst=1 exactly while in RECOVER.

- IDLE:
  - enable && frame_start → START.
  - frame_start with enable=0 → frames_dropped++.
- START:
  - ap_start held until ap_ready is sampled high; then → RUN, so ap_start drops the following cycle.
  - ap_ready && ap_done in the same cycle → frames_done++, → IDLE.
- RUN:
  - ap_done → frames_done++, → IDLE.
- Frame launch rate: one launch per frame_start. Any frame_start seen in a state other than IDLE → frames_dropped++. Pulses are not queued.
- Watchdog:
  - wdog clears on every state entry and increments each cycle in START/RUN/DRAIN.
  - wdog == WDOG_LIMIT-1 in START/RUN → RECOVER, err_code=2.
  - wdog == WDOG_LIMIT-1 in DRAIN → RECOVER, err_code=3.
- Deadlock persistence:
  - persist counter counts consecutive dl_block=1 cycles, only in START/RUN.
  - It clears on dl_block=0 or on leaving START/RUN.
  - Reaching PERSIST → RECOVER, err_code=1.
- Same-cycle priority: ap_done > deadlock > watchdog. A completing frame is never reported as an error.
- RECOVER:
  - Entry: err_valid=1 for one cycle, recover_cnt++.
  - core_rst held RST_CYCLES cycles, then → DRAIN.
- DRAIN: wait for ap_idle=1 with core_rst=0, then → IDLE. dl_block is ignored in DRAIN.
- enable deasserted mid-frame: the current frame runs to completion or recovery; no further launches.
- Saturation: all counters saturate at all-ones, with no wrap.
- Asynchronous reset mid-operation: ap_start and core_rst fall immediately, without waiting for a clock edge.

Test Plan:
- Normal frame: enable=1, frame_start; ap_ready 3 cycles later, ap_done 50 cycles later.
  → ap_start high 4 cycles; busy drops the cycle after ap_done; frames_done=1, err_valid never.
- Frame_start in RUN: second frame_start 10 cycles after launch.
  → frames_dropped=1, no second ap_start, frames_done=1 after ap_done.
- Deadlock threshold (PERSIST=16): dl_block high 15 cycles, low 1, then high 16 cycles in RUN.
  → no recovery after the first 15; RECOVER after the 16-cycle run; err_code=1, err_valid single pulse, core_rst high exactly 8 cycles, recover_cnt=1.
- Watchdog (WDOG_LIMIT=100): ap_ready never returned.
  → RECOVER entered 100 cycles after START entry, err_code=2.
  - Then hold ap_idle=0 in DRAIN → second recovery with err_code=3.
  - Then assert ap_idle → IDLE.
- Priority: ap_done asserted in the same cycle dl_block completes its 16th cycle.
  → frames_done++, no err_valid, FSM=IDLE.
- Async reset mid-operation: assert reset during RUN, and separately during RECOVER, between clock edges.
  → ap_start, core_rst and busy go 0 before the next edge; counters 0; FSM=IDLE after release.
